// File: rtl/sorted_drain.sv
// sorted_drain: serializing read-out stage for the sorting network.
// Accepts one sorted N-element vector per input handshake and emits its
// elements in stored order (element 0 first), one per output handshake,
// with an index and a last marker. The next vector can be accepted on the
// same cycle the final element leaves, so back-to-back vectors stream with
// no bubble.
// Optional feature: define SORT_DRAIN_DUP_FLAG_EN to add the out_dup port,
// which flags an element equal to its predecessor within the same vector.
module sorted_drain #(
  parameter int W = 8,
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_idx,
  output logic           out_last
`ifdef SORT_DRAIN_DUP_FLAG_EN
  ,
  output logic           out_dup
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  localparam logic [2:0] LAST_IDX = 3'(N - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_idx;
  logic [N-1:0][W-1:0]   r_buf;
  logic                  w_in_hs;
  logic                  w_out_hs;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: leave DRAIN only when the last element leaves with no refill
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_in_hs) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_hs && out_last && !w_in_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs and handshakes; in_ready follows out_ready combinationally so
  // the refill can coincide with the final element's departure
  always_comb begin
    out_valid = (r_state == S_DRAIN);
    out_last  = (r_idx == LAST_IDX);
    out_idx   = r_idx;
    out_data  = r_buf[r_idx];
    w_out_hs  = out_valid & out_ready;
    in_ready  = !rst & ((r_state == S_IDLE) | (w_out_hs & out_last));
    w_in_hs   = in_valid & in_ready;
  end

  // Vector buffer and element index; buffer changes only on input handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (w_in_hs) begin
      r_idx <= '0;
      r_buf <= in_data;
    end else if (w_out_hs) begin
      r_idx <= out_last ? 3'd0 : r_idx + 3'd1;
    end
  end

`ifdef SORT_DRAIN_DUP_FLAG_EN
  logic [2:0] w_prev_idx;

  // Duplicate flag: compare current element with its predecessor; element 0
  // never has a predecessor so the flag is forced low there
  always_comb begin
    w_prev_idx = (r_idx == 3'd0) ? 3'd0 : r_idx - 3'd1;
    out_dup    = out_valid & (r_idx != 3'd0) & (r_buf[r_idx] == r_buf[w_prev_idx]);
  end
`endif

endmodule

// File: tb/tb_sorted_drain.sv
// Testbench for sorted_drain: table of input vectors with their expected
// duplicate flags, a scoreboard queue filled on each input handshake and
// drained on each output handshake, plus hand-written reset sequences.
module tb_sorted_drain;

  localparam int W = 8;
  localparam int N = 5;
  localparam int BUDGET = 80;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_idx;
  logic           out_last;
`ifdef SORT_DRAIN_DUP_FLAG_EN
  logic           out_dup;
`endif

  sorted_drain #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef SORT_DRAIN_DUP_FLAG_EN
    ,
    .out_dup   (out_dup)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][W-1:0] e;    // element k in e[k]
    logic [N-1:0]        dup;  // expected out_dup for element k
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   idx;
    logic         last;
    logic         dup;
  } exp_t;

  vec_t tbl [7];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic stall_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push_vec(input int t);
    exp_t x;
    for (int k = 0; k < N; k++) begin
      x.data = tbl[t].e[k];
      x.idx  = 3'(k);
      x.last = (k == N - 1);
      x.dup  = tbl[t].dup[k];
      sb.push_back(x);
    end
  endtask

  task automatic pop_chk();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("out_data", 32'(out_data), 32'(x.data));
      chk("out_idx",  32'(out_idx),  32'(x.idx));
      chk("out_last", 32'(out_last), 32'(x.last));
`ifdef SORT_DRAIN_DUP_FLAG_EN
      chk("out_dup",  32'(out_dup),  32'(x.dup));
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive table vectors first..first+nvec-1 with in_valid held high while
  // any remain; optionally hold out_ready low for stall_len cycles once the
  // stream reaches element stall_idx.
  task automatic run_stream(input int first, input int nvec, input int stall_idx, input int stall_len);
    int vi = 0, pops = 0, cyc = 0, nvalid = 0;
    int first_v = -1, last_v = -1, hs_cyc = -1, pop1 = -1;
    int stall_left = stall_len;
    while (1) begin
      if (vi == nvec && sb.size() == 0 && !out_valid) break;
      if (cyc >= BUDGET) begin
        chk("stream_timeout", 32'(cyc), 32'(BUDGET - 1));
        break;
      end
      in_valid = (vi < nvec);
      if (vi < nvec) in_data = tbl[first + vi].e;
      if (out_valid && stall_left > 0 && int'(out_idx) == stall_idx) begin
        out_ready  = 1'b0;
        stall_left--;
        stall_chk  = 1'b1;
      end else begin
        out_ready  = 1'b1;
        stall_chk  = 1'b0;
      end
      @(negedge clk);
      if (stall_chk) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data",  32'(out_data),  32'(sb[0].data));
        chk("stall_idx",   32'(out_idx),   32'(sb[0].idx));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (out_valid && out_ready) begin
        pop_chk();
        pops++;
        if (pop1 < 0) pop1 = cyc;
      end
      if (in_valid && in_ready) begin
        if (vi > 0) chk("refill_on_last", 32'(out_valid & out_ready & out_last), 32'd1);
        if (hs_cyc < 0) hs_cyc = cyc;
        push_vec(first + vi);
        vi++;
      end
      cycle();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stall_chk = 1'b0;
    chk("idle_after",  32'(out_valid), 32'd0);
    chk("pop_count",   32'(pops), 32'(N * nvec));
    chk("latency",     32'(pop1 - hs_cyc), 32'd1);
    chk("valid_contig", 32'(nvalid), 32'(last_v - first_v + 1));
    chk("valid_cycles", 32'(nvalid), 32'(N * nvec + stall_len));
  endtask

  initial begin
    tbl[0].e = {8'd200, 8'd41, 8'd20, 8'd9, 8'd3};   tbl[0].dup = 5'b00000;
    tbl[1].e = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};       tbl[1].dup = 5'b00000;
    tbl[2].e = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};  tbl[2].dup = 5'b00000;
    tbl[3].e = {8'd7, 8'd7, 8'd7, 8'd5, 8'd5};       tbl[3].dup = 5'b11010;
    tbl[4].e = {8'd0, 8'd0, 8'd128, 8'd0, 8'd255};   tbl[4].dup = 5'b10000;
    tbl[5].e = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0};       tbl[5].dup = 5'b11110;
    tbl[6].e = {8'd104, 8'd103, 8'd102, 8'd101, 8'd100}; tbl[6].dup = 5'b00000;

    // Reset held 3 cycles with in_valid high
    rst = 1'b1; in_valid = 1'b1; in_data = tbl[0].e; out_ready = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_idx",   32'(out_idx),   32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
`ifdef SORT_DRAIN_DUP_FLAG_EN
      chk("rst_out_dup",   32'(out_dup),   32'd0);
`endif
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single vector, then back-to-back pair, then backpressure on element 2
    run_stream(0, 1, -1, 0);
    run_stream(1, 2, -1, 0);
    run_stream(3, 2, 2, 4);

    // Reset while element 2 is presented
    in_valid = 1'b1; in_data = tbl[5].e; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_hs", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_pre_idx", 32'(out_idx), 32'(i));
      cycle();
    end
    chk("mid_at_idx2", 32'(out_idx), 32'd2);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    cycle();
    rst = 1'b0; out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_idx",   32'(out_idx),   32'd0);
    chk("mid_out_data",  32'(out_data),  32'd0);
    chk("mid_in_ready",  32'(in_ready),  32'd1);
    cycle();
    run_stream(6, 1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
